// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared branch definitions: operation codes, flag bit positions, FSM states
// and the small helpers used by the resolve controller and its condition evaluator.
package branch_resolve_ctrl_pkg;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_JMP  = 4'd1;
    localparam logic [3:0] BR_AEQ  = 4'd2;
    localparam logic [3:0] BR_ANE  = 4'd3;
    localparam logic [3:0] BR_ACS  = 4'd4;
    localparam logic [3:0] BR_ACC  = 4'd5;
    localparam logic [3:0] BR_AMI  = 4'd6;
    localparam logic [3:0] BR_APL  = 4'd7;
    localparam logic [3:0] BR_BEQ  = 4'd8;
    localparam logic [3:0] BR_BNE  = 4'd9;
    localparam logic [3:0] BR_BCS  = 4'd10;
    localparam logic [3:0] BR_BCC  = 4'd11;
    localparam logic [3:0] BR_BMI  = 4'd12;
    localparam logic [3:0] BR_BPL  = 4'd13;

    // Flag vectors are packed {N,Z,C}
    localparam int FL_N = 2;
    localparam int FL_Z = 1;
    localparam int FL_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RESOLVE  = 2'd2,
        ST_REDIRECT = 2'd3
    } br_state_e;

    typedef enum logic [1:0] {
        DEP_NONE = 2'd0,
        DEP_A    = 2'd1,
        DEP_B    = 2'd2
    } br_dep_e;

    function automatic br_dep_e br_dep(input logic [3:0] code);
        if (code >= BR_AEQ && code <= BR_APL) return DEP_A;
        if (code >= BR_BEQ && code <= BR_BPL) return DEP_B;
        return DEP_NONE;
    endfunction

    // 2-bit saturating up/down count; simultaneous issue and done cancel out
    function automatic logic [1:0] pend_next(input logic [1:0] cnt,
                                             input logic iss, input logic done);
        if (iss && !done && cnt != 2'd3) return cnt + 2'd1;
        if (done && !iss && cnt != 2'd0) return cnt - 2'd1;
        return cnt;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: selects flag set A or B by code and
// tests one flag with the requested polarity.
module branch_cond_eval
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [3:0] iCode,
    input  logic [2:0] iFlagsA,
    input  logic [2:0] iFlagsB,
    output logic       oTaken
);

    logic [2:0] w_flags;

    always_comb begin
        w_flags = (br_dep(iCode) == DEP_B) ? iFlagsB : iFlagsA;
        case (iCode)
            BR_JMP:         oTaken = 1'b1;
            BR_AEQ, BR_BEQ: oTaken = w_flags[FL_Z];
            BR_ANE, BR_BNE: oTaken = !w_flags[FL_Z];
            BR_ACS, BR_BCS: oTaken = w_flags[FL_C];
            BR_ACC, BR_BCC: oTaken = !w_flags[FL_C];
            BR_AMI, BR_BMI: oTaken = w_flags[FL_N];
            BR_APL, BR_BPL: oTaken = !w_flags[FL_N];
            default:        oTaken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: holds decode while the flags a branch depends
// on are still in flight, then redirects fetch for taken branches.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 10,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iBranchValid,
    input  logic [3:0]          iBranchOperation,
    input  logic [PC_WIDTH-1:0] iBranchTarget,
    input  logic                iFlagIssueA,
    input  logic                iFlagIssueB,
    input  logic                iFlagDoneA,
    input  logic                iFlagDoneB,
    input  logic [2:0]          iFlagsA,
    input  logic [2:0]          iFlagsB,
    output logic                oStall,
    output logic                oFlush,
    output logic                oPCSel,
    output logic [PC_WIDTH-1:0] oPCTarget,
    output logic                oTimeout,
    output logic [15:0]         oTakenCount
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    br_state_e           r_state, w_next;
    logic [3:0]          r_op;
    logic [PC_WIDTH-1:0] r_target;
    logic [1:0]          r_pend_a, r_pend_b;
    logic [1:0]          w_pend_a_nxt, w_pend_b_nxt;
    logic [7:0]          r_wait;
    logic [15:0]         r_taken_cnt;
    logic                r_timeout;
    logic                w_accept, w_timeout, w_taken, w_dep_busy;
    logic [3:0]          w_dep_op;

    assign w_pend_a_nxt = pend_next(r_pend_a, iFlagIssueA, iFlagDoneA);
    assign w_pend_b_nxt = pend_next(r_pend_b, iFlagIssueB, iFlagDoneB);
    assign w_accept     = (r_state == ST_IDLE) && iBranchValid && (iBranchOperation != BR_NONE);

    // Dependency is judged on the count as it stands after this edge, so a
    // Done in the same cycle releases the branch immediately.
    always_comb begin
        w_dep_op = (r_state == ST_IDLE) ? iBranchOperation : r_op;
        case (br_dep(w_dep_op))
            DEP_A:   w_dep_busy = (w_pend_a_nxt != 2'd0);
            DEP_B:   w_dep_busy = (w_pend_b_nxt != 2'd0);
            default: w_dep_busy = 1'b0;
        endcase
    end

    branch_cond_eval u_cond (
        .iCode   (r_op),
        .iFlagsA (iFlagsA),
        .iFlagsB (iFlagsB),
        .oTaken  (w_taken)
    );

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = w_dep_busy ? ST_WAIT : ST_RESOLVE;
            end
            ST_WAIT: begin
                if (!w_dep_busy) begin
                    w_next = ST_RESOLVE;
                end else if (r_wait == WAIT_LAST) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_RESOLVE:  w_next = w_taken ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oStall      = (r_state != ST_IDLE) || w_accept;
        oPCSel      = (r_state == ST_REDIRECT);
        oFlush      = (r_state == ST_REDIRECT);
        oPCTarget   = (r_state == ST_REDIRECT) ? r_target : '0;
        oTimeout    = r_timeout;
        oTakenCount = r_taken_cnt;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_op        <= BR_NONE;
            r_target    <= '0;
            r_pend_a    <= 2'd0;
            r_pend_b    <= 2'd0;
            r_wait      <= 8'd0;
            r_timeout   <= 1'b0;
            r_taken_cnt <= 16'd0;
        end else begin
            r_pend_a  <= w_pend_a_nxt;
            r_pend_b  <= w_pend_b_nxt;
            r_timeout <= w_timeout;
            if (w_accept) begin
                r_op     <= iBranchOperation;
                r_target <= iBranchTarget;
            end
            if (r_state == ST_WAIT && w_next == ST_WAIT) r_wait <= r_wait + 8'd1;
            else                                         r_wait <= 8'd0;
            if (r_state == ST_REDIRECT) r_taken_cnt <= r_taken_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: expected redirect/timeout events are
// queued at issue time and matched against the DUT as they appear.
module tb_branch_resolve_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iBranchValid;
    logic [3:0] iBranchOperation;
    logic [9:0] iBranchTarget;
    logic       iFlagIssueA, iFlagIssueB, iFlagDoneA, iFlagDoneB;
    logic [2:0] iFlagsA, iFlagsB;
    logic       oStall, oFlush, oPCSel, oTimeout;
    logic [9:0] oPCTarget;
    logic [15:0] oTakenCount;

    typedef struct {
        logic       is_to;
        logic [9:0] tgt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_taken = 0;
    int   t0;

    branch_resolve_ctrl #(.PC_WIDTH(10), .WAIT_LIMIT(15)) dut (
        .Clock(Clock), .Reset(Reset),
        .iBranchValid(iBranchValid), .iBranchOperation(iBranchOperation),
        .iBranchTarget(iBranchTarget),
        .iFlagIssueA(iFlagIssueA), .iFlagIssueB(iFlagIssueB),
        .iFlagDoneA(iFlagDoneA), .iFlagDoneB(iFlagDoneB),
        .iFlagsA(iFlagsA), .iFlagsB(iFlagsB),
        .oStall(oStall), .oFlush(oFlush), .oPCSel(oPCSel),
        .oPCTarget(oPCTarget), .oTimeout(oTimeout), .oTakenCount(oTakenCount)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Reference condition: index table rather than a case list
    function automatic logic ref_taken(input logic [3:0] code, input logic [2:0] fa,
                                       input logic [2:0] fb);
        int k;
        logic [2:0] f;
        int idx;
        if (code == 4'd1) return 1'b1;
        if (code < 4'd2 || code > 4'd13) return 1'b0;
        f   = (code < 4'd8) ? fa : fb;
        k   = (int'(code) - 2) % 6;
        idx = (k / 2 == 0) ? 1 : (k / 2 == 1) ? 0 : 2;
        return f[idx] ^ k[0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic is_to, input logic [9:0] tgt, input int at);
        exp_t x;
        x.is_to = is_to; x.tgt = tgt; x.cyc = at;
        sb.push_back(x);
    endtask

    task automatic branch(input logic [3:0] op, input logic [9:0] tgt);
        iBranchValid = 1'b1; iBranchOperation = op; iBranchTarget = tgt;
    endtask

    task automatic unbranch();
        iBranchValid = 1'b0; iBranchOperation = 4'd0; iBranchTarget = 10'd0;
    endtask

    // Scoreboard: every redirect or timeout pulse must match the queue head
    always @(negedge Clock) begin
        if (!Reset) begin
            if (oPCSel || oTimeout) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_event pcsel=%0b timeout=%0b tgt=%0h cyc=%0d",
                           oPCSel, oTimeout, oPCTarget, cyc);
                end else begin
                    e = sb.pop_front();
                    assert (oTimeout === e.is_to && oPCSel === !e.is_to && oFlush === oPCSel &&
                            oPCTarget === (e.is_to ? 10'd0 : e.tgt) && cyc === e.cyc)
                    else begin
                        errors++;
                        $error("FAIL event observed to=%0b sel=%0b fl=%0b tgt=%0h cyc=%0d expected to=%0b tgt=%0h cyc=%0d",
                               oTimeout, oPCSel, oFlush, oPCTarget, cyc, e.is_to, e.tgt, e.cyc);
                    end
                end
            end else begin
                checks++;
                assert (oFlush === 1'b0 && oPCTarget === 10'd0)
                else begin
                    errors++;
                    $error("FAIL idle_outputs observed fl=%0b tgt=%0h expected 0/0 cyc=%0d",
                           oFlush, oPCTarget, cyc);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1;
        unbranch();
        iFlagIssueA = 0; iFlagIssueB = 0; iFlagDoneA = 0; iFlagDoneB = 0;
        iFlagsA = 3'b000; iFlagsB = 3'b000;
        tick(2);
        chk("rst_stall", oStall, 0);
        chk("rst_pcsel", oPCSel, 0);
        chk("rst_flush", oFlush, 0);
        chk("rst_target", oPCTarget, 0);
        chk("rst_timeout", oTimeout, 0);
        chk("rst_taken", oTakenCount, 0);
        branch(4'd1, 10'h155); #1;
        chk("rst_stall_valid", oStall, 1);
        unbranch(); Reset = 1'b0;
        tick(1);

        // JMP, no dependency: redirect two cycles after accept
        t0 = cyc; branch(4'd1, 10'h155); push(0, 10'h155, t0 + 2); #1;
        chk("jmp_stall_accept", oStall, 1);
        tick(1); unbranch(); #1;
        chk("jmp_stall_resolve", oStall, 1);
        tick(2); exp_taken++;
        chk("jmp_taken", oTakenCount, 32'(exp_taken));
        chk("jmp_stall_done", oStall, 0);

        // BAEQ waits on PendA; a stray branch during WAIT must be ignored
        iFlagsA = 3'b010;
        iFlagIssueA = 1; tick(1); iFlagIssueA = 0;
        t0 = cyc; branch(4'd2, 10'h0A5); push(0, 10'h0A5, t0 + 5);
        tick(1); branch(4'd1, 10'h3FF);
        tick(2); unbranch(); iFlagDoneA = 1; #1;
        chk("baeq_stall_wait", oStall, 1);
        tick(1); iFlagDoneA = 0;
        tick(2); exp_taken++;
        chk("baeq_taken", oTakenCount, 32'(exp_taken));

        // BBNE with Z_B=1: not taken, back to IDLE at T+2
        iFlagsB = 3'b010;
        t0 = cyc; branch(4'd9, 10'h0F0);
        tick(1); unbranch();
        tick(1);
        chk("bbne_idle", oStall, 0);
        tick(1);
        chk("bbne_taken", oTakenCount, 32'(exp_taken));

        // Sweep all codes with random flags against the reference condition
        for (int c = 0; c < 16; c++) begin
            logic [9:0] tg;
            iFlagsA = 3'($urandom_range(0, 7));
            iFlagsB = 3'($urandom_range(0, 7));
            tg = 10'($urandom_range(1, 1023));
            t0 = cyc; branch(4'(c), tg); #1;
            chk("sweep_stall", oStall, (c != 0) ? 1 : 0);
            if (ref_taken(4'(c), iFlagsA, iFlagsB)) begin
                push(0, tg, t0 + 2); exp_taken++;
            end
            tick(1); unbranch();
            tick(2);
        end
        chk("sweep_taken", oTakenCount, 32'(exp_taken));

        // BACS with PendA stuck: timeout after 15 WAIT cycles, no redirect
        iFlagIssueA = 1; tick(1); iFlagIssueA = 0;
        t0 = cyc; branch(4'd4, 10'h111); push(1, 10'd0, t0 + 16);
        tick(1); unbranch(); #1;
        chk("bacs_stall_wait", oStall, 1);
        tick(19);
        chk("bacs_stall_after", oStall, 0);
        chk("bacs_taken", oTakenCount, 32'(exp_taken));
        iFlagDoneA = 1; tick(1); iFlagDoneA = 0; tick(1);

        // Saturation: 4 issues -> 3, issue+done -> 3, 2 dones -> 1
        iFlagsA = 3'b010;
        iFlagIssueA = 1; tick(4);
        iFlagDoneA = 1; tick(1);
        iFlagIssueA = 0; tick(2); iFlagDoneA = 0;
        t0 = cyc; branch(4'd2, 10'h2AA); push(0, 10'h2AA, t0 + 3); exp_taken++;
        tick(1); unbranch(); iFlagDoneA = 1;
        tick(1); iFlagDoneA = 0;
        tick(2);

        // Floor at 0: extra dones, then one issue must still cause a wait
        iFlagDoneA = 1; tick(2); iFlagDoneA = 0;
        iFlagIssueA = 1; tick(1); iFlagIssueA = 0;
        t0 = cyc; branch(4'd2, 10'h00F); push(0, 10'h00F, t0 + 3); exp_taken++;
        tick(1); unbranch(); iFlagDoneA = 1;
        tick(1); iFlagDoneA = 0;
        tick(2);

        // PendB outstanding must not delay a set-A branch
        iFlagIssueB = 1; tick(1); iFlagIssueB = 0;
        t0 = cyc; branch(4'd2, 10'h0C3); push(0, 10'h0C3, t0 + 2); exp_taken++;
        tick(1); unbranch();
        tick(2);
        iFlagDoneB = 1; tick(1); iFlagDoneB = 0;
        chk("pend_taken", oTakenCount, 32'(exp_taken));

        // Reset while in WAIT: silent return to IDLE, everything cleared
        iFlagIssueA = 1; tick(1); iFlagIssueA = 0;
        t0 = cyc; branch(4'd2, 10'h1E1);
        tick(1); unbranch();
        tick(1); Reset = 1'b1;
        tick(1);
        chk("rstw_stall", oStall, 0);
        chk("rstw_pcsel", oPCSel, 0);
        chk("rstw_flush", oFlush, 0);
        chk("rstw_timeout", oTimeout, 0);
        chk("rstw_taken", oTakenCount, 0);
        Reset = 1'b0; exp_taken = 0;
        tick(1);
        t0 = cyc; branch(4'd2, 10'h1E1); push(0, 10'h1E1, t0 + 2); exp_taken++;
        tick(1); unbranch();
        tick(2);
        chk("rstw_pend_cleared", oTakenCount, 32'(exp_taken));

        // Taken counter wraps from 0xFFFF to 0
        dut.r_taken_cnt = 16'hFFFF;
        t0 = cyc; branch(4'd1, 10'h3FF); push(0, 10'h3FF, t0 + 2);
        tick(1); unbranch();
        tick(2);
        chk("taken_wrap", oTakenCount, 0);

        tick(2);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
